// File: rtl/lab6_dpath_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lab6_dpath_arbiter
// Purpose  : Round-robin sharing of one lab6dpath between requesters A and B,
//            with an in-order tag FIFO routing each result back to its issuer.
// Revision : 1.0
// ============================================================================
module lab6_dpath_arbiter #(
    parameter  int WIDTH   = 10,
    parameter  int MAX_OUT = 4,
    localparam int CW      = $clog2(MAX_OUT + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic signed [WIDTH-1:0] a_x1,
    input  logic signed [WIDTH-1:0] a_x2,
    input  logic signed [WIDTH-1:0] a_x3,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic signed [WIDTH-1:0] b_x1,
    input  logic signed [WIDTH-1:0] b_x2,
    input  logic signed [WIDTH-1:0] b_x3,
    output logic                    dp_irdy,
    output logic signed [WIDTH-1:0] dp_din,
    input  logic                    dp_ordy,
    input  logic signed [WIDTH-1:0] dp_dout,
    output logic                    a_y_valid,
    output logic                    b_y_valid,
    output logic signed [WIDTH-1:0] y,
    output logic [CW-1:0]           outstanding,
    output logic                    err
);

    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND2 = 2'd1;
    localparam logic [1:0] S_SEND3 = 2'd2;

    localparam logic [CW-1:0] c_MAX_OUT  = CW'(MAX_OUT);
    localparam logic [PW-1:0] c_LAST_PTR = PW'(MAX_OUT - 1);

    logic [1:0]              r_state;
    logic signed [WIDTH-1:0] r_x2;
    logic signed [WIDTH-1:0] r_x3;
    logic                    r_prio;     // 0 = A has priority, 1 = B
    logic                    r_tag [0:MAX_OUT-1];
    logic [PW-1:0]           r_wp;
    logic [PW-1:0]           r_rp;
    logic [CW-1:0]           r_count;
    logic signed [WIDTH-1:0] r_y;
    logic                    r_a_yv;
    logic                    r_b_yv;
    logic                    r_err;

    logic w_grant;
    logic w_win_b;
    logic w_pop;
    logic w_head_tag;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Occupancy is sampled before this cycle's pop, so a returning result
    // never frees a slot for a grant in the same cycle.
    assign w_grant    = !reset && (r_state == S_IDLE) && (a_valid || b_valid)
                        && (r_count < c_MAX_OUT);
    assign w_win_b    = b_valid && (!a_valid || r_prio);
    assign w_pop      = !reset && dp_ordy && (r_count != '0);
    assign w_head_tag = r_tag[r_rp];

    assign a_ready     = w_grant && !w_win_b;
    assign b_ready     = w_grant && w_win_b;
    assign dp_irdy     = w_grant;
    assign a_y_valid   = r_a_yv;
    assign b_y_valid   = r_b_yv;
    assign y           = r_y;
    assign outstanding = r_count;
    assign err         = r_err;

    always_comb begin
        dp_din = '0;
        if (!reset) begin
            case (r_state)
                S_IDLE:  if (w_grant) dp_din = w_win_b ? b_x1 : a_x1;
                S_SEND2: dp_din = r_x2;
                S_SEND3: dp_din = r_x3;
                default: dp_din = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x2    <= '0;
            r_x3    <= '0;
            r_prio  <= 1'b0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_y     <= '0;
            r_a_yv  <= 1'b0;
            r_b_yv  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  if (w_grant) r_state <= S_SEND2;
                S_SEND2: r_state <= S_SEND3;
                default: r_state <= S_IDLE;
            endcase

            if (w_grant) begin
                r_x2   <= w_win_b ? b_x2 : a_x2;
                r_x3   <= w_win_b ? b_x3 : a_x3;
                r_prio <= !w_win_b;
                r_wp   <= f_next(r_wp);
            end

            r_a_yv <= w_pop && !w_head_tag;
            r_b_yv <= w_pop && w_head_tag;
            if (w_pop) begin
                r_y  <= dp_dout;
                r_rp <= f_next(r_rp);
            end

            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (dp_ordy && (r_count == '0)) r_err <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read behind the occupancy count.
    always_ff @(posedge clk) begin
        if (w_grant) r_tag[r_wp] <= w_win_b;
    end

endmodule
`default_nettype wire

// File: tb/tb_lab6_dpath_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_lab6_dpath_arbiter
// Purpose  : Self-checking bench: queue-based reference model plus directed
//            literal checks and randomized traffic.
// Revision : 1.0
// ============================================================================
module tb_lab6_dpath_arbiter;

    localparam int W  = 10;
    localparam int MO = 4;
    localparam int CW = $clog2(MO + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic a_valid = 1'b0, b_valid = 1'b0, dp_ordy = 1'b0;
    logic signed [W-1:0] a_x1 = '0, a_x2 = '0, a_x3 = '0;
    logic signed [W-1:0] b_x1 = '0, b_x2 = '0, b_x3 = '0;
    logic signed [W-1:0] dp_dout = '0;
    logic a_ready, b_ready, dp_irdy, a_y_valid, b_y_valid, err;
    logic signed [W-1:0] dp_din, y;
    logic [CW-1:0] outstanding;

    always #5 clk = ~clk;

    lab6_dpath_arbiter #(.WIDTH(W), .MAX_OUT(MO)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_x1(a_x1), .a_x2(a_x2), .a_x3(a_x3),
        .b_valid(b_valid), .b_ready(b_ready), .b_x1(b_x1), .b_x2(b_x2), .b_x3(b_x3),
        .dp_irdy(dp_irdy), .dp_din(dp_din), .dp_ordy(dp_ordy), .dp_dout(dp_dout),
        .a_y_valid(a_y_valid), .b_y_valid(b_y_valid), .y(y),
        .outstanding(outstanding), .err(err)
    );

    int vec = 0;
    int mis = 0;

    // Reference model: issued tags in order, operands still to be sent.
    bit                  m_tag[$];
    logic signed [W-1:0] m_din[$];
    bit                  m_prio, m_err, m_ayv, m_byv, m_known;
    logic signed [W-1:0] m_y;

    // DUT outputs captured at the falling edge of the current cycle.
    logic s_ar, s_br, s_irdy, s_ayv, s_byv, s_err;
    logic signed [W-1:0] s_din, s_y;
    logic [CW-1:0] s_out;

    task automatic chk(input string nm, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        vec++;
        if (got !== exp) begin
            mis++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, exp);
        end
    endtask

    task automatic cycle();
        bit g, wb, pop;
        logic signed [W-1:0] ed;
        @(negedge clk);
        s_ar = a_ready; s_br = b_ready; s_irdy = dp_irdy; s_din = dp_din;
        s_ayv = a_y_valid; s_byv = b_y_valid; s_y = y; s_out = outstanding; s_err = err;

        g  = !reset && (m_din.size() == 0) && (a_valid || b_valid) && (m_tag.size() < MO);
        wb = b_valid && (!a_valid || m_prio);
        ed = '0;
        if (g) ed = wb ? b_x1 : a_x1;
        else if (!reset && m_din.size() > 0) ed = m_din[0];

        chk("a_ready", s_ar, g && !wb);
        chk("b_ready", s_br, g && wb);
        chk("dp_irdy", s_irdy, g);
        chk("dp_din", s_din, ed);
        if (m_known) begin
            chk("outstanding", s_out, m_tag.size());
            chk("a_y_valid", s_ayv, m_ayv);
            chk("b_y_valid", s_byv, m_byv);
            chk("y", s_y, m_y);
            chk("err", s_err, m_err);
        end

        if (reset) begin
            m_tag.delete(); m_din.delete();
            m_prio = 0; m_err = 0; m_ayv = 0; m_byv = 0; m_y = '0; m_known = 1;
        end else begin
            pop   = dp_ordy && (m_tag.size() > 0);
            m_ayv = pop && (m_tag[0] == 0);
            m_byv = pop && (m_tag[0] == 1);
            if (dp_ordy && m_tag.size() == 0) m_err = 1;
            if (pop) begin
                m_y = dp_dout;
                void'(m_tag.pop_front());
            end
            if (m_din.size() > 0) void'(m_din.pop_front());
            if (g) begin
                m_tag.push_back(wb);
                m_din.push_back(wb ? b_x2 : a_x2);
                m_din.push_back(wb ? b_x3 : a_x3);
                m_prio = !wb;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; a_valid = 0; b_valid = 0; dp_ordy = 0;
        cycle(); cycle();
        reset = 0;
    endtask

    initial begin
        // Single A issue
        do_reset();
        a_valid = 1; a_x1 = 3; a_x2 = -4; a_x3 = 5;
        cycle();
        chk("single_a_ready", s_ar, 1); chk("single_irdy", s_irdy, 1); chk("single_din1", s_din, 3);
        a_valid = 0;
        cycle();
        chk("single_din2", s_din, -4); chk("single_irdy2", s_irdy, 0); chk("single_out", s_out, 1);
        cycle();
        chk("single_din3", s_din, 5);
        cycle();
        dp_ordy = 1; dp_dout = -17;
        cycle();
        dp_ordy = 0;
        cycle();
        chk("single_ayv", s_ayv, 1); chk("single_y", s_y, -17);
        chk("single_byv", s_byv, 0); chk("single_out0", s_out, 0);

        // Contention: A, B, A every three cycles
        do_reset();
        a_valid = 1; a_x1 = 1; a_x2 = 2; a_x3 = 3;
        b_valid = 1; b_x1 = 4; b_x2 = 5; b_x3 = 6;
        for (int i = 0; i < 7; i++) begin
            cycle();
            if (i == 0) begin chk("cont_a0", s_ar, 1); chk("cont_din0", s_din, 1); end
            if (i == 1) chk("cont_din1", s_din, 2);
            if (i == 3) begin chk("cont_b3", s_br, 1); chk("cont_din3", s_din, 4); end
            if (i == 4) chk("cont_din4", s_din, 5);
            if (i == 6) begin chk("cont_a6", s_ar, 1); chk("cont_b6", s_br, 0); end
        end

        // Full stall, then a pop that only frees a slot for the next cycle
        do_reset();
        a_valid = 1; b_valid = 0;
        for (int i = 0; i < 16; i++) begin
            dp_ordy = (i == 14); dp_dout = 77;
            cycle();
            chk("stall_grant", s_ar, (i == 0 || i == 3 || i == 6 || i == 9 || i == 15));
            if (i == 12) chk("stall_full", s_out, 4);
        end
        dp_ordy = 0;

        // Ordering: tags A, B, A returned in issue order
        do_reset();
        a_valid = 1; b_valid = 1;
        for (int i = 0; i < 9; i++) begin
            if (i == 7) begin a_valid = 0; b_valid = 0; end
            cycle();
        end
        for (int k = 0; k < 4; k++) begin
            dp_ordy = (k < 3); dp_dout = W'(10 * (k + 1));
            cycle();
            if (k == 1) begin chk("ord_ayv1", s_ayv, 1); chk("ord_y1", s_y, 10); chk("ord_byv1", s_byv, 0); end
            if (k == 2) begin chk("ord_byv2", s_byv, 1); chk("ord_y2", s_y, 20); end
            if (k == 3) begin chk("ord_ayv3", s_ayv, 1); chk("ord_y3", s_y, 30); end
        end

        // Spurious result with nothing outstanding
        dp_ordy = 1; dp_dout = 99;
        cycle();
        dp_ordy = 0;
        cycle();
        chk("spur_err", s_err, 1); chk("spur_ayv", s_ayv, 0);
        chk("spur_byv", s_byv, 0); chk("spur_y", s_y, 30);
        cycle();
        chk("spur_sticky", s_err, 1);
        reset = 1;
        cycle();
        reset = 0;
        cycle();
        chk("spur_cleared", s_err, 0);

        // Reset during SEND2 with B waiting
        a_valid = 1; a_x1 = 1; a_x2 = 1; a_x3 = 1;
        cycle();
        reset = 1; a_valid = 0; b_valid = 1; b_x1 = 9; b_x2 = 8; b_x3 = 7;
        cycle();
        chk("rst_irdy", s_irdy, 0); chk("rst_din", s_din, 0);
        reset = 0;
        cycle();
        chk("rst_b_grant", s_br, 1); chk("rst_b_din", s_din, 9); chk("rst_out", s_out, 0);
        b_valid = 0;
        cycle(); cycle(); cycle();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (!a_valid || s_ar) begin
                a_valid = ($urandom % 3) != 0;
                a_x1 = W'($urandom); a_x2 = W'($urandom); a_x3 = W'($urandom);
            end
            if (!b_valid || s_br) begin
                b_valid = ($urandom % 3) != 0;
                b_x1 = W'($urandom); b_x2 = W'($urandom); b_x3 = W'($urandom);
            end
            dp_ordy = ((m_tag.size() > 0) && ($urandom % 3 == 0)) || ($urandom % 150 == 0);
            dp_dout = W'($urandom);
            reset   = ($urandom % 250 == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
`default_nettype wire
